// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the MEM-stage access controller: access sizes, FSM states, byte strobes.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] STRB_ALL     = 4'b1111;
  localparam logic [3:0] STRB_LO_HALF = 4'b0011;
  localparam logic [3:0] STRB_HI_HALF = 4'b1100;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  // Size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication and byte strobes, load extraction and extension.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    wdata_o = wdata_i;
    wstrb_o = STRB_ALL;
    rdata_o = rdata_i;
    byte_v  = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v  = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << addr_lo_i;
        rdata_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = addr_lo_i[1] ? STRB_HI_HALF : STRB_LO_HALF;
        rdata_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus sequencer with pipeline stall, load extension and response timeout.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses error out without a bus cycle.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_re_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        stall_o,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        err_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  state_e      state_q, state_d;
  logic        we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic [1:0]  size_q, size_d;
  logic [15:0] cnt_q, cnt_d;  // wide enough for TIMEOUT_CYCLES up to 65535

  logic        req, trap, timeout;
  logic [31:0] al_wdata, al_rdata;
  logic [3:0]  al_wstrb;

  assign req = req_re_i | req_we_i;
`ifdef MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_size_i, req_addr_i[1:0]);
`else
  assign trap = 1'b0;
`endif
  assign timeout = (TIMEOUT_CYCLES != 0) && (state_q inside {StReq, StWait}) &&
                   (({16'd0, cnt_q} + 32'd1) >= TIMEOUT_CYCLES);

  mem_lane_align u_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rdata_i    (bus_rdata_i),
    .wdata_o    (al_wdata),
    .wstrb_o    (al_wstrb),
    .rdata_o    (al_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
    end else begin
      we_q        <= we_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
    end
  end

  // Timeout beats a late ready in REQ; a response on the last allowed cycle still counts.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req) state_d = trap ? StDone : StReq;
      StReq:   if (timeout) state_d = StDone; else if (bus_ready_i) state_d = StWait;
      StWait:  if (bus_rvalid_i || timeout) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    uns_d       = uns_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (req) begin
          we_d    = req_we_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          size_d  = req_size_i;
          err_d   = trap;
          if (trap) load_data_d = '0;
        end
      end
      StReq, StWait: begin
        if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
        if (state_q == StWait && bus_rvalid_i) begin
          if (!we_q) load_data_d = al_rdata;
        end else if (timeout) begin
          err_d       = 1'b1;
          load_data_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_o      = 1'b0;
    load_valid_o = 1'b0;
    err_o        = 1'b0;
    bus_valid_o  = 1'b0;
    bus_we_o     = 1'b0;
    bus_addr_o   = '0;
    bus_wdata_o  = '0;
    bus_wstrb_o  = '0;
    unique case (state_q)
      StIdle: stall_o = req & ~rst;  // reset must release the pipeline even with a request pending
      StReq: begin
        stall_o     = 1'b1;
        bus_valid_o = 1'b1;
        bus_we_o    = we_q;
        bus_addr_o  = {addr_q[31:2], 2'b00};
        bus_wdata_o = al_wdata;
        bus_wstrb_o = we_q ? al_wstrb : STRB_ALL;
      end
      StWait: stall_o = 1'b1;
      StDone: begin
        load_valid_o = ~we_q & ~err_q;
        err_o        = err_q;
      end
      default: ;
    endcase
  end

  assign load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_re_i, req_we_i, req_unsigned_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [1:0]  req_size_i;
  logic        stall_o, load_valid_o, err_o;
  logic [31:0] load_data_o;
  logic        bus_valid_o, bus_ready_i, bus_we_o, bus_rvalid_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_wstrb_o;

  int n_checks = 0;
  int n_errors = 0;

  // Request presented during DONE when chaining back-to-back accesses.
  logic        nx_re, nx_we, nx_uns;
  logic [31:0] nx_addr, nx_wdata;
  logic [1:0]  nx_sz;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_re_i       (req_re_i),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .stall_o        (stall_o),
    .load_valid_o   (load_valid_o),
    .load_data_o    (load_data_o),
    .err_o          (err_o),
    .bus_valid_o    (bus_valid_o),
    .bus_ready_i    (bus_ready_i),
    .bus_we_o       (bus_we_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_wstrb_o    (bus_wstrb_o),
    .bus_rvalid_i   (bus_rvalid_i),
    .bus_rdata_i    (bus_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_strb(input logic [1:0] sz, input logic [31:0] a);
    logic [1:0] lo;
    lo = a[1:0];
    if (sz == 2'd0) return 32'd1 << lo;
    if (sz == 2'd1) return lo[1] ? 32'hC : 32'h3;
    return 32'hF;
  endfunction

  function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic [31:0] a,
                                           input logic uns, input logic [31:0] rd);
    logic [31:0] v;
    int          bits;
    logic [1:0]  lo;
    lo = a[1:0];
    if (sz == 2'd0) begin
      v    = (rd >> (8 * lo)) & 32'hFF;
      bits = 8;
    end else if (sz == 2'd1) begin
      v    = (rd >> (16 * lo[1])) & 32'hFFFF;
      bits = 16;
    end else begin
      return rd;
    end
    if (!uns && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
    return v;
  endfunction

  function automatic bit misaligned(input logic [1:0] sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Called at posedge+1 with the controller idle; returns at posedge+1.
  task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] sz, input logic uns,
                           input int rdly, input int vdly, input logic [31:0] rdata,
                           input bit no_ready, input bit chain);
    bit trap, timed_out, left;
    int cyc;
    trap      = misaligned(sz, addr);
    timed_out = 1'b0;
    cyc       = 0;
    req_re_i = re; req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_size_i = sz; req_unsigned_i = uns;
    @(negedge clk);
    check_eq("idle_stall", stall_o, 1);
    check_eq("idle_valid", bus_valid_o, 0);
    @(posedge clk); #1;
    req_re_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = $urandom; req_wdata_i = $urandom;
    req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
    if (!trap) begin
      left = 1'b0;
      for (int c = 0; c < 64 && !left; c++) begin
        bus_ready_i  = !no_ready && (c == rdly);
        bus_rvalid_i = bus_ready_i && ($urandom_range(0, 1) == 1);
        bus_rdata_i  = $urandom;
        @(negedge clk);
        cyc++;
        check_eq("req_valid", bus_valid_o, 1);
        check_eq("req_stall", stall_o, 1);
        check_eq("req_we", bus_we_o, we);
        check_eq("req_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
        check_eq("req_strb", bus_wstrb_o, we ? exp_strb(sz, addr) : 32'hF);
        if (we) check_eq("req_wdata", bus_wdata_o, exp_wdata(sz, wdata));
        if (cyc == int'(TO)) begin
          left = 1'b1;
          timed_out = 1'b1;
        end else if (bus_ready_i) begin
          left = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (!left) check_eq("req_bound", 0, 1);
      left = timed_out;
      for (int c = 0; c < 64 && !left; c++) begin
        bus_ready_i  = 1'b0;
        bus_rvalid_i = (c == vdly);
        bus_rdata_i  = bus_rvalid_i ? rdata : $urandom;
        @(negedge clk);
        cyc++;
        check_eq("wait_valid", bus_valid_o, 0);
        check_eq("wait_stall", stall_o, 1);
        check_eq("wait_lvalid", load_valid_o, 0);
        if (bus_rvalid_i) begin
          left = 1'b1;
        end else if (cyc == int'(TO)) begin
          left = 1'b1;
          timed_out = 1'b1;
        end
        @(posedge clk); #1;
      end
      if (!left) check_eq("wait_bound", 0, 1);
    end
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = $urandom;
    if (chain) begin
      req_re_i = nx_re; req_we_i = nx_we; req_addr_i = nx_addr; req_wdata_i = nx_wdata;
      req_size_i = nx_sz; req_unsigned_i = nx_uns;
    end
    @(negedge clk);
    check_eq("done_stall", stall_o, 0);
    check_eq("done_valid", bus_valid_o, 0);
    check_eq("done_err", err_o, trap || timed_out);
    check_eq("done_lvalid", load_valid_o, !we && !trap && !timed_out);
    if (!we) check_eq("done_ldata", load_data_o,
                      (trap || timed_out) ? 32'd0 : exp_load(sz, addr, uns, rdata));
    @(posedge clk); #1;
    if (!chain) begin
      @(negedge clk);
      check_eq("post_lvalid", load_valid_o, 0);
      check_eq("post_err", err_o, 0);
      check_eq("post_stall", stall_o, 0);
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_mid(input bit in_wait);
    req_re_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0000_0200;
    req_size_i = 2'd2; req_unsigned_i = 1'b0;
    @(posedge clk); #1;
    req_re_i = 1'b0;
    bus_ready_i = in_wait;
    if (in_wait) begin
      @(posedge clk); #1;
      bus_ready_i = 1'b0;
    end
    #1;
    check_eq("pre_rst_valid", bus_valid_o, !in_wait);
    check_eq("pre_rst_stall", stall_o, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_valid", bus_valid_o, 0);
    check_eq("rst_stall", stall_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_idle_stall", stall_o, 0);
    check_eq("rst_idle_err", err_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] sz;
    logic       re, we;
    rst = 1'b1;
    req_re_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
    req_size_i = '0; req_unsigned_i = 1'b0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    #2;
    check_eq("rst_state_valid", bus_valid_o, 0);
    check_eq("rst_state_stall", stall_o, 0);
    check_eq("rst_state_lvalid", load_valid_o, 0);
    check_eq("rst_state_ldata", load_data_o, 0);
    check_eq("rst_state_err", err_o, 0);
    check_eq("rst_state_addr", bus_addr_o, 0);
    check_eq("rst_state_strb", bus_wstrb_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_access(0, 1, 32'h100, 32'hDEAD_BEEF, 2'd2, 0, 2, 1, 32'h0, 0, 0);
    do_access(1, 0, 32'h103, 32'h0, 2'd0, 0, 0, 0, 32'h80FF_FF7F, 0, 0);
    do_access(1, 0, 32'h103, 32'h0, 2'd0, 1, 1, 2, 32'h80FF_FF7F, 0, 0);
    do_access(0, 1, 32'h102, 32'h0000_1234, 2'd1, 0, 0, 0, 32'h0, 0, 0);
    do_access(1, 0, 32'h104, 32'h0, 2'd2, 0, 0, 0, 32'h1111_2222, 1, 0);
    do_access(1, 0, 32'h108, 32'h0, 2'd1, 0, 1, 0, 32'h8000_0000, 0, 0);
    nx_re = 1'b0; nx_we = 1'b1; nx_addr = 32'h200; nx_wdata = 32'hCAFE_F00D;
    nx_sz = 2'd2; nx_uns = 1'b0;
    do_access(1, 0, 32'h10C, 32'h0, 2'd2, 0, 1, 1, 32'h5A5A_A5A5, 0, 1);
    do_access(nx_re, nx_we, nx_addr, nx_wdata, nx_sz, nx_uns, 2, 0, 32'h0, 0, 0);
    do_access(1, 0, 32'h101, 32'h0, 2'd2, 0, 0, 0, 32'h7654_3210, 0, 0);
    do_access(1, 1, 32'h302, 32'hABCD_8765, 2'd1, 0, 0, 1, 32'h0, 0, 0);
    reset_mid(1'b1);
    reset_mid(1'b0);
    do_access(1, 0, 32'h400, 32'h0, 2'd2, 0, 1, 1, 32'h0BAD_F00D, 0, 0);

    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom);
      we = 1'($urandom);
      re = we ? 1'($urandom) : 1'b1;
      do_access(re, we, $urandom, $urandom, sz, 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom, ($urandom_range(0, 15) == 0), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
